// File: rtl/vfu_issue_queue_if.sv
// Dispatch/execute/write-back signal bundle for one vfu_issue_queue instance.
// master: the surrounding pipeline (dispatch, execution unit, write-back).
// slave : the issue queue itself.
interface vfu_issue_queue_if #(
  parameter int unsigned REQ_W = 64
);
  // Dispatch request
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_id;
  logic [1:0]       req_lmul;
  logic             req_wr_vd;
  logic [REQ_W-1:0] req_data;
  // Beat stream to the execution unit
  logic             ex_valid;
  logic             ex_ready;
  logic [2:0]       ex_id;
  logic [2:0]       ex_beat;
  logic             ex_last;
  logic [REQ_W-1:0] ex_data;
  // Write-back observation
  logic             wb_valid;
  logic             wb_last;
  logic [2:0]       wb_id;
  // Scoreboard completion strobes
  logic             resp_vs_valid;
  logic             resp_vd_valid;
  logic [2:0]       resp_id;
  logic [2:0]       resp_vd_id;
  logic             err;

  modport master (
    output req_valid, req_id, req_lmul, req_wr_vd, req_data,
    output ex_ready, wb_valid, wb_last, wb_id,
    input  req_ready, ex_valid, ex_id, ex_beat, ex_last, ex_data,
    input  resp_vs_valid, resp_vd_valid, resp_id, resp_vd_id, err
  );

  modport slave (
    input  req_valid, req_id, req_lmul, req_wr_vd, req_data,
    input  ex_ready, wb_valid, wb_last, wb_id,
    output req_ready, ex_valid, ex_id, ex_beat, ex_last, ex_data,
    output resp_vs_valid, resp_vd_valid, resp_id, resp_vd_id, err
  );
endinterface

// File: rtl/vfu_issue_queue.sv
// Per-functional-unit vector issue queue: buffers dispatched instructions,
// sequences one beat per LMUL register to the execution unit, and returns
// source-read (vs) and destination-write (vd) completion strobes in order.
// Optional feature: define VFU_IS_BYPASS_EN to present a request as beat 0
// in the same cycle when the instruction queue is empty.
module vfu_issue_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CQ_DEPTH = 4,
  parameter int unsigned REQ_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  vfu_issue_queue_if.slave bus
);

  localparam int unsigned IQ_AW = $clog2(DEPTH);
  localparam int unsigned IQ_PW = IQ_AW + 1;
  localparam int unsigned CQ_AW = $clog2(CQ_DEPTH);
  localparam int unsigned CQ_PW = CQ_AW + 1;

`ifdef VFU_IS_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]       id;
    logic [1:0]       lmul;
    logic             wr_vd;
    logic [REQ_W-1:0] data;
  } iq_entry_t;

  typedef struct packed {
    logic [2:0] id;
    logic       wr_vd;
  } cq_entry_t;

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_e;

  state_e           state_q, state_d;
  iq_entry_t        iq_mem [DEPTH];
  cq_entry_t        cq_mem [CQ_DEPTH];
  logic [IQ_PW-1:0] iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
  logic [CQ_PW-1:0] cq_wr_q, cq_wr_d, cq_rd_q, cq_rd_d;
  logic [2:0]       beat_q, beat_d;
  logic             resp_vs_q, resp_vs_d, resp_vd_q, resp_vd_d;
  logic [2:0]       resp_id_q, resp_id_d, resp_vd_id_q, resp_vd_id_d;
  logic             err_q, err_d;

  iq_entry_t  iq_head, req_entry, src;
  cq_entry_t  cq_head;
  logic       iq_empty, iq_full, cq_empty, cq_full;
  logic       src_valid, beat_last, ex_valid_c;
  logic [2:0] ex_id_c, ex_beat_c;
  logic       ex_last_c;
  logic [REQ_W-1:0] ex_data_c;
  logic       ex_fire, last_fire, byp_done, iq_push, iq_pop;
  logic       wb_last_ev, wb_match, cq_retire, err_ev;

  // Queue status and head views
  assign iq_empty = (iq_wr_q == iq_rd_q);
  assign iq_full  = (iq_wr_q[IQ_PW-1] != iq_rd_q[IQ_PW-1]) &&
                    (iq_wr_q[IQ_AW-1:0] == iq_rd_q[IQ_AW-1:0]);
  assign cq_empty = (cq_wr_q == cq_rd_q);
  assign cq_full  = (cq_wr_q[CQ_PW-1] != cq_rd_q[CQ_PW-1]) &&
                    (cq_wr_q[CQ_AW-1:0] == cq_rd_q[CQ_AW-1:0]);
  assign iq_head  = iq_mem[iq_rd_q[IQ_AW-1:0]];
  assign cq_head  = cq_mem[cq_rd_q[CQ_AW-1:0]];
  assign req_entry = '{id: bus.req_id, lmul: bus.req_lmul,
                       wr_vd: bus.req_wr_vd, data: bus.req_data};

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Sequencer next state: issuing whenever the instruction queue holds an entry
  always_comb begin
    state_d = state_q;
    if (iq_wr_d != iq_rd_d) state_d = S_ISSUE;
    else                    state_d = S_IDLE;
  end

  // Sequencer outputs: select the beat source and withhold a last beat on CQ full
  always_comb begin
    src_valid = 1'b0;
    src       = iq_head;
    unique case (state_q)
      S_ISSUE: src_valid = 1'b1;
      S_IDLE: begin
        if (BYPASS_EN) begin
          src_valid = bus.req_valid;
          src       = req_entry;
        end
      end
      default: ;
    endcase
    beat_last  = (beat_q == 3'((4'd1 << src.lmul) - 4'd1));
    ex_valid_c = src_valid & ~(beat_last & cq_full);
    ex_id_c    = src_valid ? src.id : 3'd0;
    ex_beat_c  = src_valid ? beat_q : 3'd0;
    ex_last_c  = src_valid & beat_last;
    ex_data_c  = src_valid ? src.data : '0;
  end

  assign bus.req_ready     = ~iq_full;
  assign bus.ex_valid      = ex_valid_c;
  assign bus.ex_id         = ex_id_c;
  assign bus.ex_beat       = ex_beat_c;
  assign bus.ex_last       = ex_last_c;
  assign bus.ex_data       = ex_data_c;
  assign bus.resp_vs_valid = resp_vs_q;
  assign bus.resp_vd_valid = resp_vd_q;
  assign bus.resp_id       = resp_id_q;
  assign bus.resp_vd_id    = resp_vd_id_q;
  assign bus.err           = err_q;

  // Handshake events; a bypassed single-beat request never enters the IQ
  assign ex_fire    = ex_valid_c & bus.ex_ready;
  assign last_fire  = ex_fire & beat_last;
  assign byp_done   = BYPASS_EN & (state_q == S_IDLE) & last_fire;
  assign iq_push    = bus.req_valid & ~iq_full & ~byp_done;
  assign iq_pop     = last_fire & (state_q == S_ISSUE);
  assign wb_last_ev = bus.wb_valid & bus.wb_last;
  assign wb_match   = wb_last_ev & ~cq_empty & cq_head.wr_vd & (bus.wb_id == cq_head.id);
  assign cq_retire  = ~cq_empty & (~cq_head.wr_vd | wb_match);
  assign err_ev     = wb_last_ev & ~wb_match;

  // Next-state for pointers, beat counter and completion strobes
  always_comb begin
    iq_wr_d      = iq_wr_q + IQ_PW'(iq_push);
    iq_rd_d      = iq_rd_q + IQ_PW'(iq_pop);
    cq_wr_d      = cq_wr_q + CQ_PW'(last_fire);
    cq_rd_d      = cq_rd_q + CQ_PW'(cq_retire);
    beat_d       = beat_q;
    resp_vs_d    = last_fire;
    resp_id_d    = resp_id_q;
    resp_vd_d    = cq_retire;
    resp_vd_id_d = resp_vd_id_q;
    err_d        = err_q | err_ev;
    if (last_fire)    beat_d = 3'd0;
    else if (ex_fire) beat_d = beat_q + 3'd1;
    if (last_fire)    resp_id_d = src.id;
    if (cq_retire)    resp_vd_id_d = cq_head.id;
  end

  // Control registers, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iq_wr_q      <= '0;
      iq_rd_q      <= '0;
      cq_wr_q      <= '0;
      cq_rd_q      <= '0;
      beat_q       <= 3'd0;
      resp_vs_q    <= 1'b0;
      resp_id_q    <= 3'd0;
      resp_vd_q    <= 1'b0;
      resp_vd_id_q <= 3'd0;
      err_q        <= 1'b0;
    end else begin
      iq_wr_q      <= iq_wr_d;
      iq_rd_q      <= iq_rd_d;
      cq_wr_q      <= cq_wr_d;
      cq_rd_q      <= cq_rd_d;
      beat_q       <= beat_d;
      resp_vs_q    <= resp_vs_d;
      resp_id_q    <= resp_id_d;
      resp_vd_q    <= resp_vd_d;
      resp_vd_id_q <= resp_vd_id_d;
      err_q        <= err_d;
    end
  end

  // Queue storage; contents are meaningful only between the pointers
  always_ff @(posedge clk) begin
    if (iq_push)   iq_mem[iq_wr_q[IQ_AW-1:0]] <= req_entry;
    if (last_fire) cq_mem[cq_wr_q[CQ_AW-1:0]] <= '{id: src.id, wr_vd: src.wr_vd};
  end

endmodule

// File: tb/tb_vfu_issue_queue.sv
// Self-checking bench for vfu_issue_queue: a directed vector table, directed
// corner sequences and randomized traffic checked against a queue-based model.
module tb_vfu_issue_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned CQ_DEPTH = 4;
  localparam int unsigned REQ_W    = 64;
`ifdef VFU_IS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  id;
    logic [1:0]  lmul;
    logic        wr_vd;
    logic [63:0] data;
  } req_t;

  typedef struct packed {
    logic [2:0] id;
    logic       wr_vd;
  } cqe_t;

  typedef struct {
    logic rv; logic [2:0] rid; logic [1:0] lmul; logic wrvd;
    logic exr; logic wbv; logic wbl; logic [2:0] wbid;
    logic e_rdy; logic e_exv; logic [2:0] e_beat; logic e_last; logic [2:0] e_exid;
    logic e_vs; logic [2:0] e_vsid; logic e_vd; logic [2:0] e_vdid; logic e_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vfu_issue_queue_if #(.REQ_W(REQ_W)) bus ();

  vfu_issue_queue #(.DEPTH(DEPTH), .CQ_DEPTH(CQ_DEPTH), .REQ_W(REQ_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: instruction list, beat position, completion list
  req_t       iq_m[$];
  cqe_t       cq_m[$];
  int         beat_m;
  logic       m_vs, m_vd, m_err;
  logic [2:0] m_vs_id, m_vd_id;
  logic [2:0] beat_log[$];
  logic [2:0] vd_log[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic vec_t mk(int rv, int rid, int lm, int wv, int exr, int wbv, int wbl,
                              int wbid, int rdy, int exv, int bt, int lst, int exid,
                              int vs, int vsid, int vd, int vdid, int er);
    vec_t v;
    v.rv = 1'(rv); v.rid = 3'(rid); v.lmul = 2'(lm); v.wrvd = 1'(wv);
    v.exr = 1'(exr); v.wbv = 1'(wbv); v.wbl = 1'(wbl); v.wbid = 3'(wbid);
    v.e_rdy = 1'(rdy); v.e_exv = 1'(exv); v.e_beat = 3'(bt); v.e_last = 1'(lst);
    v.e_exid = 3'(exid); v.e_vs = 1'(vs); v.e_vsid = 3'(vsid); v.e_vd = 1'(vd);
    v.e_vdid = 3'(vdid); v.e_err = 1'(er);
    return v;
  endfunction

  task automatic idle_inputs();
    bus.req_valid = 1'b0; bus.req_id = 3'd0; bus.req_lmul = 2'd0;
    bus.req_wr_vd = 1'b0; bus.req_data = 64'd0; bus.ex_ready = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_last = 1'b0; bus.wb_id = 3'd0;
  endtask

  task automatic set_req(bit v, int id, int lm, bit wv);
    bus.req_valid = v; bus.req_id = 3'(id); bus.req_lmul = 2'(lm); bus.req_wr_vd = wv;
    bus.req_data  = {32'hC0DE0000 | 32'(id), $urandom};
  endtask

  task automatic set_wb(bit v, bit l, int id);
    bus.wb_valid = v; bus.wb_last = l; bus.wb_id = 3'(id);
  endtask

  // Compare DUT against the model for this cycle, then advance the model
  task automatic model_step();
    req_t h;
    bit   present, last, pv, acc, push, ret, e;
    int   nb;
    present = (iq_m.size() > 0);
    h = present ? iq_m[0] : req_t'(0);
    if (!present && BYP && bus.req_valid) begin
      present = 1'b1;
      h = '{id: bus.req_id, lmul: bus.req_lmul, wr_vd: bus.req_wr_vd, data: bus.req_data};
    end
    nb   = 1 << int'(h.lmul);
    last = present && (beat_m == nb - 1);
    pv   = present && !(last && cq_m.size() == CQ_DEPTH);
    check("req_ready", 64'(bus.req_ready), 64'(iq_m.size() < DEPTH));
    check("ex_valid", 64'(bus.ex_valid), 64'(pv));
    if (pv) begin
      check("ex_id", 64'(bus.ex_id), 64'(h.id));
      check("ex_beat", 64'(bus.ex_beat), 64'(beat_m));
      check("ex_last", 64'(bus.ex_last), 64'(last));
      check("ex_data", bus.ex_data, h.data);
    end
    check("resp_vs_valid", 64'(bus.resp_vs_valid), 64'(m_vs));
    if (m_vs) check("resp_id", 64'(bus.resp_id), 64'(m_vs_id));
    check("resp_vd_valid", 64'(bus.resp_vd_valid), 64'(m_vd));
    if (m_vd) check("resp_vd_id", 64'(bus.resp_vd_id), 64'(m_vd_id));
    check("err", 64'(bus.err), 64'(m_err));
    if (bus.ex_valid && bus.ex_ready) beat_log.push_back(bus.ex_id);
    if (bus.resp_vd_valid) vd_log.push_back(bus.resp_vd_id);

    acc  = pv && bus.ex_ready;
    push = bus.req_valid && (iq_m.size() < DEPTH);
    e = bus.wb_valid && bus.wb_last &&
        (cq_m.size() == 0 || !cq_m[0].wr_vd || bus.wb_id != cq_m[0].id);
    ret = 1'b0;
    if (cq_m.size() > 0)
      ret = !cq_m[0].wr_vd || (bus.wb_valid && bus.wb_last && bus.wb_id == cq_m[0].id);
    m_vd = ret;
    if (ret) begin
      m_vd_id = cq_m[0].id;
      void'(cq_m.pop_front());
    end
    m_vs = acc && last;
    if (m_vs) m_vs_id = h.id;
    if (e) m_err = 1'b1;
    if (acc) begin
      if (last) begin
        beat_m = 0;
        cq_m.push_back('{id: h.id, wr_vd: h.wr_vd});
        if (iq_m.size() > 0) void'(iq_m.pop_front());
        else push = 1'b0;
      end else begin
        beat_m++;
      end
    end
    if (push)
      iq_m.push_back('{id: bus.req_id, lmul: bus.req_lmul, wr_vd: bus.req_wr_vd, data: bus.req_data});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    #2;
    model_step();
    tick();
  endtask

  // Assert reset, check reset values at once, then release and clear the model
  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    check("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_vs", 64'(bus.resp_vs_valid), 64'd0);
    check("rst_resp_vd", 64'(bus.resp_vd_valid), 64'd0);
    check("rst_resp_id", 64'(bus.resp_id), 64'd0);
    check("rst_resp_vd_id", 64'(bus.resp_vd_id), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    iq_m.delete(); cq_m.delete(); beat_m = 0;
    m_vs = 1'b0; m_vd = 1'b0; m_err = 1'b0; m_vs_id = 3'd0; m_vd_id = 3'd0;
  endtask

  initial begin
    vec_t tbl[15];
    apply_reset();

`ifndef VFU_IS_BYPASS_EN
    // Single lmul=2 instruction, then error handling on a mismatched wb_last
    tbl[0]  = mk(1,5,2,1, 1, 0,0,0, 1,0,0,0,0, 0,0,0,0,0);
    tbl[1]  = mk(0,0,0,0, 1, 0,0,0, 1,1,0,0,5, 0,0,0,0,0);
    tbl[2]  = mk(0,0,0,0, 1, 0,0,0, 1,1,1,0,5, 0,0,0,0,0);
    tbl[3]  = mk(0,0,0,0, 1, 0,0,0, 1,1,2,0,5, 0,0,0,0,0);
    tbl[4]  = mk(0,0,0,0, 1, 0,0,0, 1,1,3,1,5, 0,0,0,0,0);
    tbl[5]  = mk(0,0,0,0, 1, 1,1,5, 1,0,0,0,0, 1,5,0,0,0);
    tbl[6]  = mk(0,0,0,0, 1, 0,0,0, 1,0,0,0,0, 0,0,1,5,0);
    tbl[7]  = mk(0,0,0,0, 1, 0,0,0, 1,0,0,0,0, 0,0,0,0,0);
    tbl[8]  = mk(1,4,0,1, 1, 0,0,0, 1,0,0,0,0, 0,0,0,0,0);
    tbl[9]  = mk(0,0,0,0, 1, 0,0,0, 1,1,0,1,4, 0,0,0,0,0);
    tbl[10] = mk(0,0,0,0, 1, 1,1,3, 1,0,0,0,0, 1,4,0,0,0);
    tbl[11] = mk(0,0,0,0, 1, 1,1,4, 1,0,0,0,0, 0,0,0,0,1);
    tbl[12] = mk(0,0,0,0, 1, 0,0,0, 1,0,0,0,0, 0,0,1,4,1);
    tbl[13] = mk(0,0,0,0, 1, 1,0,7, 1,0,0,0,0, 0,0,0,0,1);
    tbl[14] = mk(0,0,0,0, 1, 0,0,0, 1,0,0,0,0, 0,0,0,0,1);
    for (int i = 0; i < 15; i++) begin
      set_req(tbl[i].rv, int'(tbl[i].rid), int'(tbl[i].lmul), tbl[i].wrvd);
      bus.ex_ready = tbl[i].exr;
      set_wb(tbl[i].wbv, tbl[i].wbl, int'(tbl[i].wbid));
      #2;
      check($sformatf("tbl%0d_req_ready", i), 64'(bus.req_ready), 64'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_ex_valid", i), 64'(bus.ex_valid), 64'(tbl[i].e_exv));
      if (tbl[i].e_exv) begin
        check($sformatf("tbl%0d_ex_beat", i), 64'(bus.ex_beat), 64'(tbl[i].e_beat));
        check($sformatf("tbl%0d_ex_last", i), 64'(bus.ex_last), 64'(tbl[i].e_last));
        check($sformatf("tbl%0d_ex_id", i), 64'(bus.ex_id), 64'(tbl[i].e_exid));
      end
      check($sformatf("tbl%0d_resp_vs", i), 64'(bus.resp_vs_valid), 64'(tbl[i].e_vs));
      if (tbl[i].e_vs) check($sformatf("tbl%0d_resp_id", i), 64'(bus.resp_id), 64'(tbl[i].e_vsid));
      check($sformatf("tbl%0d_resp_vd", i), 64'(bus.resp_vd_valid), 64'(tbl[i].e_vd));
      if (tbl[i].e_vd) check($sformatf("tbl%0d_resp_vd_id", i), 64'(bus.resp_vd_id), 64'(tbl[i].e_vdid));
      check($sformatf("tbl%0d_err", i), 64'(bus.err), 64'(tbl[i].e_err));
      model_step();
      tick();
    end
    apply_reset();
`endif

    // Fill the IQ with four lmul=3 instructions while the unit stalls
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, i, 3, 1'b0);
      cycle();
    end
    set_req(1'b0, 0, 0, 1'b0);
    #2;
    check("fill_req_ready", 64'(bus.req_ready), 64'd0);
    model_step();
    tick();
    beat_log.delete();
    bus.ex_ready = 1'b1;
    for (int i = 0; i < 32; i++) cycle();
    check("fill_beat_count", 64'(beat_log.size()), 64'd32);
    for (int k = 0; k < 32 && k < beat_log.size(); k++)
      check($sformatf("fill_beat%0d_id", k), 64'(beat_log[k]), 64'(k / 8));
    repeat (4) cycle();

    // Store behind ALU: vd completions stay in order
    apply_reset();
    vd_log.delete();
    bus.ex_ready = 1'b1;
    set_req(1'b1, 1, 0, 1'b1); cycle();
    set_req(1'b1, 2, 0, 1'b0); cycle();
    set_req(1'b0, 0, 0, 1'b0);
    repeat (4) cycle();
    check("order_no_early_vd", 64'(vd_log.size()), 64'd0);
    set_wb(1'b1, 1'b1, 1); cycle();
    set_wb(1'b0, 1'b0, 0);
    repeat (3) cycle();
    check("order_vd_count", 64'(vd_log.size()), 64'd2);
    if (vd_log.size() == 2) begin
      check("order_vd_first", 64'(vd_log[0]), 64'd1);
      check("order_vd_second", 64'(vd_log[1]), 64'd2);
    end

    // CQ full withholds the next last beat until one write-back retires
    apply_reset();
    bus.ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, i, 0, 1'b1);
      cycle();
    end
    set_req(1'b1, 4, 1, 1'b1); cycle();
    set_req(1'b0, 0, 0, 1'b0);
    repeat (4) cycle();
    #2;
    check("cqfull_hold", 64'(bus.ex_valid), 64'd0);
    model_step();
    tick();
    set_wb(1'b1, 1'b1, 0); cycle();
    set_wb(1'b0, 1'b0, 0);
    #2;
    check("cqfull_release_valid", 64'(bus.ex_valid), 64'd1);
    check("cqfull_release_last", 64'(bus.ex_last), 64'd1);
    model_step();
    tick();
    for (int i = 1; i <= 4; i++) begin
      set_wb(1'b1, 1'b1, i);
      cycle();
    end
    set_wb(1'b0, 1'b0, 0);
    repeat (3) cycle();

    // Reset in the middle of a long burst
    apply_reset();
    bus.ex_ready = 1'b1;
    set_req(1'b1, 6, 3, 1'b1); cycle();
    set_req(1'b1, 7, 3, 1'b1); cycle();
    set_req(1'b0, 0, 0, 1'b0);
    repeat (2) cycle();
    apply_reset();
    repeat (3) cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      set_req(($urandom_range(0, 99) < 50), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      bus.ex_ready = ($urandom_range(0, 99) < 70);
      set_wb(1'b0, 1'b0, 0);
      if (cq_m.size() > 0 && cq_m[0].wr_vd && $urandom_range(0, 99) < 40)
        set_wb(1'b1, 1'b1, int'(cq_m[0].id));
      else if ($urandom_range(0, 99) < 10)
        set_wb(1'b1, 1'b0, int'($urandom_range(0, 7)));
      cycle();
    end
    idle_inputs();
    repeat (4) cycle();

`ifdef VFU_IS_BYPASS_EN
    // Bypass: single-beat request on an empty IQ issues in the same cycle
    apply_reset();
    bus.ex_ready = 1'b1;
    set_req(1'b1, 3, 0, 1'b0);
    #2;
    check("byp_same_cycle", 64'(bus.ex_valid), 64'd1);
    model_step();
    tick();
    set_req(1'b0, 0, 0, 1'b0);
    #2;
    check("byp_resp_vs", 64'(bus.resp_vs_valid), 64'd1);
    check("byp_resp_id", 64'(bus.resp_id), 64'd3);
    model_step();
    tick();
    repeat (3) cycle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vfu_issue_queue.md
# vfu_issue_queue

Per-functional-unit issue queue on the execution side of the dispatch interface. It accepts dispatched vector instructions over a valid/ready handshake and sequences each one to its execution unit as one beat per register of the LMUL group. It returns the two completion strobes the dispatch scoreboard consumes: `resp_vs_valid` when all source reads are done, which releases WAR hazards, and `resp_vd_valid` when the destination write-back is done, which releases RAW and WAW hazards. Both strobes carry the 3-bit scoreboard id. One instance sits behind each of the ALU, MAC, LD, ST, MSK and SLD request ports.

## Interface
Parameters:
- `DEPTH`, 4: instruction queue entries (power of 2, ≥2).
- `CQ_DEPTH`, 4: in-order completion-queue entries (power of 2, ≥2).
- `REQ_W`, 64: opaque payload width passed through to the execution unit.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: dispatch request valid.
- `req_ready` out 1: queue can accept a request.
- `req_id` in 3: scoreboard id.
- `req_lmul` in 2: beat count is 1<<req_lmul (1, 2, 4 or 8).
- `req_wr_vd` in 1: instruction writes vd.
- `req_data` in REQ_W: payload.
- `ex_valid` out 1: beat presented to the execution unit.
- `ex_ready` in 1: execution unit accepts the beat.
- `ex_id` out 3: id of the current beat.
- `ex_beat` out 3: beat index 0..7.
- `ex_last` out 1: final beat of the instruction.
- `ex_data` out REQ_W: payload of the head entry.
- `wb_valid` in 1: write-back beat.
- `wb_last` in 1: final write-back beat of an instruction.
- `wb_id` in 3: id of the write-back.
- `resp_vs_valid` out 1: source reads complete (1-cycle pulse).
- `resp_vd_valid` out 1: destination written (1-cycle pulse).
- `resp_id` out 3: id for `resp_vs_valid`.
- `resp_vd_id` out 3: id for `resp_vd_valid`.
- `err` out 1: sticky protocol error flag.

## Operation
- Instruction queue (IQ): a DEPTH-entry circular FIFO holding {id, lmul, wr_vd, data}.
  - `req_ready = ~iq_full`.
  - A push happens on `req_valid & req_ready`.
- Beat sequencer states:
  - IDLE: IQ empty. `ex_valid=0`.
  - ISSUE: head entry present. `ex_valid=1`, `ex_beat=beat_cnt`, `ex_last=(beat_cnt==(1<<lmul)-1)`.
  - An accepted beat (`ex_valid & ex_ready`) increments `beat_cnt`.
  - An accepted last beat pops the IQ, resets `beat_cnt` to 0, pushes {id, wr_vd} into the completion queue (CQ), and registers `resp_vs_valid`/`resp_id` for the next cycle.
  - Backpressure rule: on the last beat, `ex_valid` is held low while the CQ is full. Non-last beats are never gated by the CQ.
- Completion queue (CQ): an in-order CQ_DEPTH FIFO. At most one retire per cycle.
  - Head with `wr_vd=1` retires on `wb_valid & wb_last & (wb_id==head.id)`.
  - Head with `wr_vd=0` retires in the first cycle it is at the head.
  - A retire registers `resp_vd_valid=1` and `resp_vd_id=head.id` for the next cycle.
  - `wb_valid & ~wb_last` is a data beat only and changes no state.
- Error conditions: `err` sets and stays set until reset; the offending event is otherwise ignored. Causes:
  - `wb_valid & wb_last` with the CQ empty;
  - `wb_valid & wb_last` with head `wr_vd=0`;
  - `wb_valid & wb_last` with `wb_id != head.id`.
- Simultaneous IQ push and pop while full: not accepted (`req_ready=0`), no bypass of fullness.
- Simultaneous IQ push and pop at another occupancy: the count is unchanged.
- Simultaneous CQ push and retire: both occur.
- Wrap-around: pointers are log2(DEPTH)+1 bits. Full when MSBs differ and LSBs are equal.

## Timing
- Reset values:
  - Pointers, `beat_cnt`, `resp_vs_valid`, `resp_vd_valid`, `err` = 0.
  - `resp_id`, `resp_vd_id` = 0.
  - `ex_valid` = 0; `req_ready` = 1.
- Reset mid-operation discards all queued and in-flight entries. No responses are emitted for them.
- Request accepted at cycle T with the IQ empty: beat 0 is presented at T+1 (see Configuration for the bypass variant).
- A 2^L-beat instruction with `ex_ready` held high occupies exactly 2^L consecutive cycles. Back-to-back instructions issue with no bubble.
- Last beat accepted at T:
  - `resp_vs_valid` at T+1.
  - For a `wr_vd=0` instruction with the CQ empty, `resp_vd_valid` at T+2.
- `wb_last` matching the head at T: `resp_vd_valid` at T+1.
- `resp_vs_valid` and `resp_vd_valid` may pulse in the same cycle with different ids.

## Configuration
- `VFU_IS_BYPASS_EN`:
  - Defined: when the IQ is empty, `req_valid` is presented combinationally as beat 0 in the same cycle (`ex_valid=req_valid`). If that beat is accepted and it is the last beat, the request never occupies the IQ.
  - Undefined: minimum one-cycle IQ latency, as in Timing.

## Test plan
- Single request, id=5, lmul=2, wr_vd=1, `ex_ready=1` → beats 0..3 on cycles T+1..T+4 with `ex_last` on beat 3; `resp_vs_valid` with id 5 at T+5. Then `wb_last` with id 5 → `resp_vd_valid` with id 5 next cycle.
- Fill DEPTH=4 lmul=3 requests with `ex_ready=0` → `req_ready=0` after the 4th push. Release `ex_ready` → 32 consecutive beats; ids are emitted in push order.
- Store-type id=2 (wr_vd=0) issued behind an ALU id=1 (wr_vd=1) → `resp_vd_valid` for id 2 appears only after id 1's `wb_last` retires it, in order 1 then 2.
- CQ full (4 outstanding with no write-back) → the next instruction's last beat is withheld (`ex_valid=0` on it). One `wb_last` → the beat issues on the following cycle.
- `wb_last` with id 3 while head id=4 → `err=1` and no `resp_vd_valid`. Assert `rst` mid-burst → all outputs return to reset values immediately.
- With `VFU_IS_BYPASS_EN`: lmul=0 request on an empty IQ with `ex_ready=1` → `ex_valid` in the same cycle; `resp_vs_valid` at T+1.
